// File: rtl/mem_port_arbiter.sv
// Arbiter between fetch and load/store ports for a single-ported main memory.
// Optional MEM_ARB_RR_EN selects round-robin instead of D priority with starvation guard.
module mem_port_arbiter #(
    parameter logic [31:0] STARTING_ADDR = 32'h0100_0000,
    parameter int          MEM_WAIT      = 0,
    parameter int          STARVE_LIMIT  = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_read_write,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR} state_t;

    state_t      state, state_nx;
    logic        cur_d, cur_we;
    logic [1:0]  cur_size;
    logic [31:0] cur_addr, cur_wdata, merge_word, merged, shifted, load_val;
    logic [3:0]  wait_cnt;
    logic        can_grant, pend_i, pend_d, pick_i, pick_d, misalign;
    logic        cur_word;

`ifdef MEM_ARB_RR_EN
    logic        last_d;
`else
    logic [7:0]  starve_cnt;
`endif

    assign can_grant = ~i_ack & ~d_ack;
    assign pend_i    = i_req & can_grant;
    assign pend_d    = d_req & can_grant;
    assign misalign  = (d_size == 2'b01 && d_addr[0]) ||
                       (d_size[1] && d_addr[1:0] != 2'b00);
`ifdef MEM_ARB_RR_EN
    assign pick_d    = pend_d & (~pend_i | ~last_d);
`else
    assign pick_d    = pend_d & (~pend_i | (starve_cnt != 8'(STARVE_LIMIT)));
`endif
    assign pick_i    = pend_i & ~pick_d;
    assign cur_word  = cur_size[1];
    assign busy      = (state != IDLE);
    assign mem_address = (state == IDLE) ? STARTING_ADDR
                                         : {cur_addr[31:2], 2'b00};

    // Load extraction and sub-word merge lanes
    always_comb begin
        shifted = mem_data_out >> {cur_addr[1:0], 3'b000};
        merged  = merge_word;
        if (cur_size == 2'b00) begin
            load_val = {24'h0, shifted[7:0]};
            merged[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
        end else if (cur_size == 2'b01) begin
            load_val = {16'h0, shifted[15:0]};
            merged[{cur_addr[1], 4'b0000} +: 16] = cur_wdata[15:0];
        end else begin
            load_val = mem_data_out;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and memory write strobe
    always_comb begin
        state_nx       = state;
        mem_read_write = 1'b0;
        mem_data_in    = 32'h0;
        unique case (state)
            IDLE: begin
                if (pick_i || (pick_d && !misalign)) state_nx = ACCESS;
            end
            ACCESS: begin
                if (wait_cnt == 4'd0) begin
                    if (cur_d && cur_we && !cur_word) begin
                        state_nx = RMW_WR;
                    end else begin
                        state_nx = IDLE;
                    end
                    if (cur_d && cur_we && cur_word) begin
                        mem_read_write = 1'b1;
                        mem_data_in    = cur_wdata;
                    end
                end
            end
            RMW_WR: begin
                mem_read_write = 1'b1;
                mem_data_in    = merged;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Request latching, wait counting, acks and read data
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            i_rdata    <= 32'h0;
            d_rdata    <= 32'h0;
            cur_d      <= 1'b0;
            cur_we     <= 1'b0;
            cur_size   <= 2'b10;
            cur_addr   <= STARTING_ADDR;
            cur_wdata  <= 32'h0;
            merge_word <= 32'h0;
            wait_cnt   <= 4'd0;
`ifdef MEM_ARB_RR_EN
            last_d     <= 1'b0;
`else
            starve_cnt <= 8'd0;
`endif
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    wait_cnt <= 4'(MEM_WAIT);
                    if (pick_d) begin
                        cur_d     <= 1'b1;
                        cur_we    <= d_we;
                        cur_size  <= d_size;
                        cur_addr  <= d_addr;
                        cur_wdata <= d_wdata;
                        if (misalign) begin
                            d_ack <= 1'b1;
                            d_err <= 1'b1;
                        end
`ifdef MEM_ARB_RR_EN
                        last_d <= 1'b1;
`else
                        if (pend_i) starve_cnt <= starve_cnt + 8'd1;
`endif
                    end else if (pick_i) begin
                        cur_d    <= 1'b0;
                        cur_we   <= 1'b0;
                        cur_size <= 2'b10;
                        cur_addr <= i_addr;
`ifdef MEM_ARB_RR_EN
                        last_d <= 1'b0;
`else
                        starve_cnt <= 8'd0;
`endif
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else if (!cur_d) begin
                        i_rdata <= mem_data_out;
                        i_ack   <= 1'b1;
                    end else if (!cur_we) begin
                        d_rdata <= load_val;
                        d_ack   <= 1'b1;
                    end else if (cur_word) begin
                        d_ack <= 1'b1;
                    end else begin
                        merge_word <= mem_data_out;
                    end
                end
                RMW_WR: d_ack <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with behavioural main memories.
// Instance u0 runs with no wait states, u1 with three.
module tb_mem_port_arbiter;

    localparam logic [31:0] SA = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_init = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic        i_req0 = 0, i_ack0, d_req0 = 0, d_we0 = 0, d_ack0, d_err0;
    logic [31:0] i_addr0 = 0, i_rdata0, d_addr0 = 0, d_wdata0 = 0, d_rdata0;
    logic [1:0]  d_size0 = 0;
    logic [31:0] mem_addr0, mem_din0, mem_dout0;
    logic        mem_rw0, busy0;
    logic [31:0] mem0 [16];
    int          wr_cnt0;

    logic        i_req1 = 0, i_ack1, d_req1 = 0, d_ack1, d_err1;
    logic [31:0] i_rdata1, d_addr1 = 0, d_rdata1;
    logic [31:0] mem_addr1, mem_din1, mem_dout1;
    logic        mem_rw1, busy1;
    logic [31:0] mem1 [16];

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARTING_ADDR(SA), .MEM_WAIT(0), .STARVE_LIMIT(4)) u0 (
        .clock(clk), .reset_n(reset_n),
        .i_req(i_req0), .i_addr(i_addr0), .i_ack(i_ack0), .i_rdata(i_rdata0),
        .d_req(d_req0), .d_we(d_we0), .d_size(d_size0), .d_addr(d_addr0),
        .d_wdata(d_wdata0), .d_ack(d_ack0), .d_rdata(d_rdata0), .d_err(d_err0),
        .mem_address(mem_addr0), .mem_data_in(mem_din0),
        .mem_data_out(mem_dout0), .mem_read_write(mem_rw0), .busy(busy0)
    );

    mem_port_arbiter #(.STARTING_ADDR(SA), .MEM_WAIT(3), .STARVE_LIMIT(4)) u1 (
        .clock(clk), .reset_n(reset_n),
        .i_req(i_req1), .i_addr(32'h0), .i_ack(i_ack1), .i_rdata(i_rdata1),
        .d_req(d_req1), .d_we(1'b0), .d_size(2'b10), .d_addr(d_addr1),
        .d_wdata(32'h0), .d_ack(d_ack1), .d_rdata(d_rdata1), .d_err(d_err1),
        .mem_address(mem_addr1), .mem_data_in(mem_din1),
        .mem_data_out(mem_dout1), .mem_read_write(mem_rw1), .busy(busy1)
    );

    function automatic logic [31:0] init_word(int k);
        if (k == 1) return 32'h1122_3344;
        return 32'h5A00_0000 | 32'(k << 8) | 32'(k);
    endfunction

    // Behavioural mainmem: combinational read, write on posedge
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 16; k++) begin
                mem0[k] <= init_word(k);
                mem1[k] <= init_word(k);
            end
            wr_cnt0 <= 0;
        end else begin
            if (mem_rw0) begin
                mem0[mem_addr0[5:2]] <= mem_din0;
                wr_cnt0 <= wr_cnt0 + 1;
            end
            if (mem_rw1) mem1[mem_addr1[5:2]] <= mem_din1;
        end
    end

    assign mem_dout0 = mem0[mem_addr0[5:2]];
    assign mem_dout1 = mem1[mem_addr1[5:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic d_go(input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
        d_we0 = we; d_size0 = sz; d_addr0 = a; d_wdata0 = wd; d_req0 = 1;
    endtask

    initial begin
        int wc;
        int cnt;
        logic [1:0] exp_g;

        tick(); tick(); tick();
        chk("rst_i_ack", i_ack0, 0);
        chk("rst_d_ack", d_ack0, 0);
        chk("rst_d_err", d_err0, 0);
        chk("rst_i_rdata", i_rdata0, 0);
        chk("rst_d_rdata", d_rdata0, 0);
        chk("rst_rw", mem_rw0, 0);
        chk("rst_addr", mem_addr0, SA);
        chk("rst_din", mem_din0, 0);
        chk("rst_busy", busy0, 0);
        mem_init = 0;
        reset_n = 1;
        tick();

        // fetch of word 2
        i_addr0 = SA + 8; i_req0 = 1;
        tick();
        chk("fetch_busy", busy0, 1);
        chk("fetch_addr", mem_addr0, SA + 8);
        chk("fetch_noack", i_ack0, 0);
        tick();
        chk("fetch_ack", i_ack0, 1);
        chk("fetch_data", i_rdata0, 32'h5A00_0202);
        i_req0 = 0;
        tick();
        chk("fetch_ack_pulse", i_ack0, 0);

        // byte store over 0x11223344
        d_go(1, 2'b00, SA + 5, 32'hFFFF_FFAB);
        tick();
        chk("sb_noack1", d_ack0, 0);
        tick();
        chk("sb_noack2", d_ack0, 0);
        chk("sb_rw", mem_rw0, 1);
        chk("sb_din", mem_din0, 32'h1122_AB44);
        tick();
        chk("sb_ack", d_ack0, 1);
        chk("sb_mem", mem0[1], 32'h1122_AB44);
        d_req0 = 0;
        tick();

        // misaligned half load
        wc = wr_cnt0;
        d_go(0, 2'b01, SA + 3, 0);
        tick();
        chk("mis_ack", d_ack0, 1);
        chk("mis_err", d_err0, 1);
        chk("mis_busy", busy0, 0);
        chk("mis_rw", mem_rw0, 0);
        d_req0 = 0;
        tick();
        chk("mis_ack_pulse", d_ack0, 0);
        chk("mis_nowrite", wr_cnt0, wc);

        // half and byte loads from word 1
        d_go(0, 2'b01, SA + 6, 0);
        tick(); tick();
        chk("lh_ack", d_ack0, 1);
        chk("lh_data", d_rdata0, 32'h0000_1122);
        chk("lh_err", d_err0, 0);
        d_req0 = 0;
        tick();
        d_go(0, 2'b00, SA + 5, 0);
        tick(); tick();
        chk("lb_ack", d_ack0, 1);
        chk("lb_data", d_rdata0, 32'h0000_00AB);
        d_req0 = 0;
        tick();

        // word store to word 3
        d_go(1, 2'b10, SA + 12, 32'hDEAD_BEEF);
        tick();
        chk("sw_rw", mem_rw0, 1);
        chk("sw_din", mem_din0, 32'hDEAD_BEEF);
        tick();
        chk("sw_ack", d_ack0, 1);
        chk("sw_mem", mem0[3], 32'hDEAD_BEEF);
        d_req0 = 0;
        tick();

        // upper half store to word 2
        d_go(1, 2'b01, SA + 10, 32'hFFFF_1234);
        tick(); tick();
        chk("sh_din", mem_din0, 32'h1234_0202);
        tick();
        chk("sh_ack", d_ack0, 1);
        chk("sh_mem", mem0[2], 32'h1234_0202);
        d_req0 = 0;
        tick();

        // both requesters held continuously
        i_addr0 = SA; i_req0 = 1;
        d_go(0, 2'b10, SA + 4, 0);
        for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_RR_EN
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_g = (k % 5 == 4) ? 2'b10 : 2'b01;
`endif
            cnt = 0;
            while (!(i_ack0 || d_ack0) && cnt < 20) begin
                tick();
                cnt++;
            end
            chk($sformatf("grant%0d", k), {i_ack0, d_ack0}, exp_g);
            tick();
        end
        i_req0 = 0; d_req0 = 0;
        tick(); tick();

        // reset during sub-word store read phase
        d_go(1, 2'b00, SA + 4, 32'h0000_0099);
        tick();
        chk("rmw_busy", busy0, 1);
        reset_n = 0;
        #1;
        chk("rr_busy", busy0, 0);
        chk("rr_rw", mem_rw0, 0);
        chk("rr_addr", mem_addr0, SA);
        chk("rr_din", mem_din0, 0);
        d_req0 = 0;
        tick(); tick();
        chk("rr_mem", mem0[1], 32'h1122_AB44);
        chk("rr_d_ack", d_ack0, 0);
        chk("rr_d_rdata", d_rdata0, 0);
        reset_n = 1;
        tick();

        // wait states on u1
        d_addr1 = SA + 8; d_req1 = 1;
        tick();
        chk("ws_busy", busy1, 1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk($sformatf("ws_noack%0d", k), d_ack1, 0);
            chk($sformatf("ws_addr%0d", k), mem_addr1, SA + 8);
        end
        tick();
        chk("ws_ack", d_ack1, 1);
        chk("ws_data", d_rdata1, 32'h5A00_0202);
        d_req1 = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
